// File: rtl/mult_error_monitor.sv
// Streaming error-statistics collector behind the approximate FP32 multiplier; optional histogram under MULT_ERR_HIST_EN.
// Latency: an accepted sample is visible in the statistics 2 cycles later; the report follows a drain of at most 2 cycles.
// Backpressure: in_ready is low outside RUN and once WINDOW samples are taken; the report is held until rpt_ready.
module mult_error_monitor #(
    parameter int WINDOW = 1024,
    parameter int ACC_W  = 48,   // must be at least 31 so one diff fits the accumulator
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        res_exact,
    input  logic [31:0]        res_approx,
    input  logic               exc,
    output logic               busy,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [ACC_W-1:0]   rpt_sum,
    output logic [30:0]        rpt_max,
    output logic [CNT_W-1:0]   rpt_nz,
    output logic [CNT_W-1:0]   rpt_samples,
    output logic [CNT_W-1:0]   rpt_skip,
`ifdef MULT_ERR_HIST_EN
    output logic [8*CNT_W-1:0] rpt_hist,
`endif
    output logic               sign_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_REPORT} state_t;

    localparam logic [CNT_W-1:0] LP_WIN     = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] LP_WIN_M1  = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;
    localparam logic [ACC_W-1:0] LP_ACC_MAX = '1;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_accepted;

    logic               w_start;
    logic               w_flush;
    logic               w_accept;
    logic               w_last;
    logic [30:0]        w_diff;
    logic [ACC_W:0]     w_sum_ext;

    logic               r_s1_vld;
    logic               r_s1_exc;
    logic               r_s1_sgn;
    logic [30:0]        r_s1_diff;

    logic [ACC_W-1:0]   r_sum;
    logic [30:0]        r_max;
    logic [CNT_W-1:0]   r_nz;
    logic [CNT_W-1:0]   r_samples;
    logic [CNT_W-1:0]   r_skip;
    logic               r_sign_err;

    // start only counts in IDLE, flush only in RUN; flush wins over a same-cycle accept
    assign w_start  = (r_state == S_IDLE) && start;
    assign w_flush  = (r_state == S_RUN) && flush;
    assign w_accept = in_valid && in_ready && !w_flush;
    assign w_last   = w_accept && (r_accepted == LP_WIN_M1);

    // Magnitude distance in ULP-ordered space, sign bits excluded
    assign w_diff    = (res_exact[30:0] >= res_approx[30:0]) ? (res_exact[30:0] - res_approx[30:0])
                                                             : (res_approx[30:0] - res_exact[30:0]);
    assign w_sum_ext = {1'b0, r_sum} + {{(ACC_W + 1 - 31){1'b0}}, r_s1_diff};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; DRAIN waits for the stage-1 register to empty into the statistics
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_RUN;
            S_RUN:    if (w_flush || w_last) w_next = S_DRAIN;
            S_DRAIN:  if (!r_s1_vld) w_next = S_REPORT;
            S_REPORT: if (rpt_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        rpt_valid = 1'b0;
        case (r_state)
            S_RUN:    begin busy = 1'b1; in_ready = (r_accepted < LP_WIN); end
            S_DRAIN:  busy = 1'b1;
            S_REPORT: begin busy = 1'b1; rpt_valid = 1'b1; end
            default:  ;
        endcase
    end

    // Accepted-sample count for the current window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_accepted <= '0;
        else if (w_start)  r_accepted <= '0;
        else if (w_accept) r_accepted <= r_accepted + LP_ONE;
    end

    // Stage 1: register diff, exception and sign mismatch of the accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_exc  <= 1'b0;
            r_s1_sgn  <= 1'b0;
            r_s1_diff <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_exc  <= exc;
                r_s1_sgn  <= res_exact[31] ^ res_approx[31];
                r_s1_diff <= w_diff;
            end
        end
    end

    // Stage 2: fold the registered sample into saturating statistics; exception samples only bump skip
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum      <= '0;
            r_max      <= '0;
            r_nz       <= '0;
            r_samples  <= '0;
            r_skip     <= '0;
            r_sign_err <= 1'b0;
        end else if (w_start) begin
            r_sum      <= '0;
            r_max      <= '0;
            r_nz       <= '0;
            r_samples  <= '0;
            r_skip     <= '0;
            r_sign_err <= 1'b0;
        end else if (r_s1_vld) begin
            if (r_s1_exc) begin
                if (r_skip != LP_CNT_MAX) r_skip <= r_skip + LP_ONE;
            end else begin
                r_sum <= w_sum_ext[ACC_W] ? LP_ACC_MAX : w_sum_ext[ACC_W-1:0];
                if (r_s1_diff > r_max) r_max <= r_s1_diff;
                if ((r_s1_diff != '0) && (r_nz != LP_CNT_MAX)) r_nz <= r_nz + LP_ONE;
                if (r_samples != LP_CNT_MAX) r_samples <= r_samples + LP_ONE;
                if (r_s1_sgn) r_sign_err <= 1'b1;
            end
        end
    end

`ifdef MULT_ERR_HIST_EN
    logic [7:0][CNT_W-1:0] r_hist;
    logic [2:0]            w_bin;

    // Bin select: 0 for zero, k for [2^(k-1), 2^k) up to 63, 7 for 64 and above
    always_comb begin
        w_bin = 3'd7;
        if      (r_s1_diff == '0) w_bin = 3'd0;
        else if (r_s1_diff < 31'd2)  w_bin = 3'd1;
        else if (r_s1_diff < 31'd4)  w_bin = 3'd2;
        else if (r_s1_diff < 31'd8)  w_bin = 3'd3;
        else if (r_s1_diff < 31'd16) w_bin = 3'd4;
        else if (r_s1_diff < 31'd32) w_bin = 3'd5;
        else if (r_s1_diff < 31'd64) w_bin = 3'd6;
    end

    // Histogram bins, saturating, non-skipped samples only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
        end else if (w_start) begin
            r_hist <= '0;
        end else if (r_s1_vld && !r_s1_exc && (r_hist[w_bin] != LP_CNT_MAX)) begin
            r_hist[w_bin] <= r_hist[w_bin] + LP_ONE;
        end
    end

    assign rpt_hist = r_hist;
`endif

    assign rpt_sum     = r_sum;
    assign rpt_max     = r_max;
    assign rpt_nz      = r_nz;
    assign rpt_samples = r_samples;
    assign rpt_skip    = r_skip;
    assign sign_err    = r_sign_err;

endmodule

// File: tb/tb_mult_error_monitor.sv
// Self-checking bench for mult_error_monitor with WINDOW=4.
// Window vectors come from a table; expected reports go through a scoreboard queue.
// Hand sequences cover backpressure, flush, ignored start/flush and asynchronous reset.
module tb_mult_error_monitor;
    localparam int ACC_W = 48;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       res_exact = '0;
    logic [31:0]       res_approx = '0;
    logic              exc = 1'b0;
    logic              busy;
    logic              rpt_valid;
    logic              rpt_ready = 1'b0;
    logic [ACC_W-1:0]  rpt_sum;
    logic [30:0]       rpt_max;
    logic [CNT_W-1:0]  rpt_nz;
    logic [CNT_W-1:0]  rpt_samples;
    logic [CNT_W-1:0]  rpt_skip;
    logic              sign_err;
`ifdef MULT_ERR_HIST_EN
    logic [8*CNT_W-1:0] rpt_hist;
`endif

    always #5 clk = ~clk;

    mult_error_monitor #(.WINDOW(4), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .res_exact(res_exact), .res_approx(res_approx), .exc(exc),
        .busy(busy), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_sum(rpt_sum), .rpt_max(rpt_max), .rpt_nz(rpt_nz),
        .rpt_samples(rpt_samples), .rpt_skip(rpt_skip),
`ifdef MULT_ERR_HIST_EN
        .rpt_hist(rpt_hist),
`endif
        .sign_err(sign_err)
    );

    typedef struct packed {
        logic [47:0]  sum;
        logic [30:0]  max;
        logic [15:0]  nz;
        logic [15:0]  samples;
        logic [15:0]  skip;
        logic         sgn;
        logic [127:0] hist;
    } rep_t;

    typedef struct {
        logic [3:0][31:0] ex;
        logic [3:0][31:0] ap;
        logic [3:0]       exc;
        rep_t             exp;
    } vec_t;

    vec_t vecs[4];
    rep_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic [127:0] mkh(input int c0, c1, c2, c3, c4, c5, c6, c7);
        return {16'(c7), 16'(c6), 16'(c5), 16'(c4), 16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    function automatic rep_t mkr(input logic [47:0] s, input logic [30:0] m, input int nz,
                                 input int samp, input int skip, input logic sg, input logic [127:0] h);
        rep_t r;
        r.sum = s; r.max = m; r.nz = 16'(nz); r.samples = 16'(samp);
        r.skip = 16'(skip); r.sgn = sg; r.hist = h;
        return r;
    endfunction

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] ex, input logic [31:0] ap, input logic e);
        int w;
        in_valid = 1'b1; res_exact = ex; res_approx = ap; exc = e;
        w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        if (!in_ready) begin
            n_total++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, w);
        end
        @(negedge clk);
        in_valid = 1'b0; exc = 1'b0;
    endtask

    task automatic wait_report(input string tag);
        int w;
        w = 0;
        while (!rpt_valid && w < 20) begin @(negedge clk); w++; end
        if (!rpt_valid) begin
            n_total++;
            $display("FAIL %s_timeout: rpt_valid=0 after %0d cycles, required 1", tag, w);
        end
    endtask

    task automatic check_report(input string tag);
        rep_t e;
        wait_report(tag);
        if (sbq.size() == 0) begin
            n_total++;
            $display("FAIL %s_scoreboard: queue size 0, required 1", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_sum"},     128'(rpt_sum),     128'(e.sum));
            chk({tag, "_max"},     128'(rpt_max),     128'(e.max));
            chk({tag, "_nz"},      128'(rpt_nz),      128'(e.nz));
            chk({tag, "_samples"}, 128'(rpt_samples), 128'(e.samples));
            chk({tag, "_skip"},    128'(rpt_skip),    128'(e.skip));
            chk({tag, "_sign"},    128'(sign_err),    128'(e.sgn));
`ifdef MULT_ERR_HIST_EN
            chk({tag, "_hist"},    128'(rpt_hist),    e.hist);
`endif
        end
        rpt_ready = 1'b1;
        @(negedge clk);
        rpt_ready = 1'b0;
        chk({tag, "_valid_drop"}, 128'(rpt_valid), 128'(0));
    endtask

    initial begin
        int acc;
        bit fall_checked;
        int w;

        // Window vectors: samples and the report they must produce
        vecs[0].ex  = {32'h3F800001, 32'h40400000, 32'h40000000, 32'h3F800000};
        vecs[0].ap  = {32'h3F800000, 32'h40400003, 32'h3FFFFFFF, 32'h3F800000};
        vecs[0].exc = 4'b0000;
        vecs[0].exp = mkr(48'd5, 31'd3, 3, 4, 0, 1'b0, mkh(1, 2, 1, 0, 0, 0, 0, 0));
        vecs[1].ex  = vecs[0].ex;
        vecs[1].ap  = vecs[0].ap;
        vecs[1].exc = 4'b0110;
        vecs[1].exp = mkr(48'd1, 31'd1, 1, 2, 2, 1'b0, mkh(1, 1, 0, 0, 0, 0, 0, 0));
        vecs[2].ex  = {32'h7F7FFFFF, 32'h00000000, 32'h00000010, 32'h3F800000};
        vecs[2].ap  = {32'h00000000, 32'h00000064, 32'h00000000, 32'hBF800000};
        vecs[2].exc = 4'b0000;
        vecs[2].exp = mkr(48'h7F800073, 31'h7F7FFFFF, 3, 4, 0, 1'b1, mkh(1, 0, 0, 0, 0, 1, 0, 2));
        vecs[3].ex  = {32'h00000000, 32'h00000005, 32'h00000001, 32'h00000000};
        vecs[3].ap  = {32'h00000064, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[3].exc = 4'b0000;
        vecs[3].exp = mkr(48'd106, 31'd100, 3, 4, 0, 1'b0, mkh(1, 1, 0, 1, 0, 0, 0, 1));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",      128'(busy),        128'(0));
        chk("rst_in_ready",  128'(in_ready),    128'(0));
        chk("rst_rpt_valid", 128'(rpt_valid),   128'(0));
        chk("rst_sum",       128'(rpt_sum),     128'(0));
        chk("rst_samples",   128'(rpt_samples), 128'(0));
        chk("rst_sign_err",  128'(sign_err),    128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // flush in IDLE is ignored
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("idle_flush_busy", 128'(busy), 128'(0));

        // Table-driven windows
        for (int v = 0; v < 4; v++) begin
            sbq.push_back(vecs[v].exp);
            start_pulse();
            for (int i = 0; i < 4; i++) send(vecs[v].ex[i], vecs[v].ap[i], vecs[v].exc[i]);
            check_report($sformatf("win%0d", v));
            if (v == 0) chk("held_after_report_sum", 128'(rpt_sum), 128'(vecs[0].exp.sum));
        end

        // Backpressure: in_valid held for 10 cycles, only 4 accepted, report held while rpt_ready=0
        sbq.push_back(mkr(48'd64, 31'd16, 4, 4, 0, 1'b0, mkh(0, 0, 0, 0, 0, 4, 0, 0)));
        start_pulse();
        in_valid = 1'b1; res_exact = 32'h00000010; res_approx = 32'h0; exc = 1'b0;
        acc = 0; fall_checked = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (acc == 4 && !fall_checked) begin
                chk("bp_ready_fall", 128'(in_ready), 128'(0));
                fall_checked = 1'b1;
            end
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_accepted", 128'(acc), 128'(4));
        wait_report("bp_hold");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid_hold", 128'(rpt_valid),   128'(1));
            chk("bp_sum_stable", 128'(rpt_sum),     128'(64));
            chk("bp_nz_stable",  128'(rpt_nz),      128'(4));
        end
        check_report("bp");

        // Flush after 2 samples; flushed-cycle sample dropped; start during REPORT ignored
        sbq.push_back(mkr(48'd1, 31'd1, 1, 2, 0, 1'b0, mkh(1, 1, 0, 0, 0, 0, 0, 0)));
        start_pulse();
        send(32'h00000021, 32'h00000020, 1'b0);
        send(32'h00000030, 32'h00000030, 1'b0);
        in_valid = 1'b1; res_exact = 32'h0; res_approx = 32'h00000050; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        wait_report("flush_pre");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("report_start_busy",  128'(busy),      128'(1));
        chk("report_start_valid", 128'(rpt_valid), 128'(1));
        check_report("flush");
        chk("flush_idle_busy", 128'(busy), 128'(0));

        // Flush with no samples gives an all-zero report
        sbq.push_back(mkr(48'd0, 31'd0, 0, 0, 0, 1'b0, mkh(0, 0, 0, 0, 0, 0, 0, 0)));
        start_pulse();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_report("zero");

        // Asynchronous reset mid-window
        start_pulse();
        send(32'h00000010, 32'h0, 1'b0);
        send(32'h00000011, 32'h0, 1'b0);
        in_valid = 1'b1;
        chk("mid_busy_before", 128'(busy), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",      128'(busy),        128'(0));
        chk("arst_in_ready",  128'(in_ready),    128'(0));
        chk("arst_rpt_valid", 128'(rpt_valid),   128'(0));
        chk("arst_sum",       128'(rpt_sum),     128'(0));
        chk("arst_samples",   128'(rpt_samples), 128'(0));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        w = 0;
        repeat (2) @(negedge clk);
        chk("post_arst_idle", 128'(busy), 128'(w));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mult_error_monitor.md
Name: mult_error_monitor

Overview:
- Streaming error-statistics collector placed directly downstream of the combinational approximate FP32 multiplier.
- Each accepted sample pairs the exact product with one approximate product (truncated, DRUM or FOIL variant, selected outside this block), together with the multiplier's Exception flag.
- Over a window of samples it accumulates absolute error, maximum error, the nonzero-error count and the skipped-sample count, then presents a report through a valid/ready handshake.
- Used for on-silicon or emulation characterisation of approximate multiplier accuracy.

Parameters:
- WINDOW, 1024: samples per report window. Legal range is 1 to 2^CNT_W-1.
- ACC_W, 48: width of the error-sum accumulator.
- CNT_W, 16: width of every sample and event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse. Clears all statistics and begins a window. Honoured only in IDLE.
- flush  in  1  single-cycle pulse. Ends the current window early. Honoured only in RUN.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- res_exact  in  32  exact FP32 product.
- res_approx  in  32  approximate FP32 product.
- exc  in  1  multiplier Exception flag for this sample.
- busy  out  1  high when state is not IDLE.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  report consumed.
- rpt_sum  out  ACC_W  saturating sum of |error|.
- rpt_max  out  31  largest |error| seen in the window.
- rpt_nz  out  CNT_W  number of samples with nonzero error.
- rpt_samples  out  CNT_W  number of samples accumulated, excluding skipped samples.
- rpt_skip  out  CNT_W  number of samples skipped because exc was high.
- sign_err  out  1  sticky flag: a sample's sign bits differed.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state is IDLE.
  - All counters, rpt_* outputs, sign_err and the pipeline valid bits are 0.
  - in_ready is 0 and rpt_valid is 0.
- Error metric:
  - |error| = |res_exact[30:0] − res_approx[30:0]|, taken as unsigned integers. This is the magnitude distance in FP32 ULP-ordered space.
  - If res_exact[31] differs from res_approx[31], set sign_err and still use the magnitude distance.
- States are IDLE, RUN, DRAIN and REPORT.
- IDLE:
  - in_ready is 0.
  - start: clear the accumulators, accepted count and sign_err, then go to RUN.
- RUN:
  - in_ready = (accepted < WINDOW).
  - A sample is accepted when in_valid and in_ready are both high; the accepted count increments.
  - Go to DRAIN when accepted reaches WINDOW or when flush arrives. Flush takes priority over a same-cycle accept, and that sample is not taken.
- Pipeline:
  - Stage 1 registers the diff, exc and sign mismatch.
  - Stage 2 updates the statistics. An accepted sample is therefore reflected in the statistics 2 cycles later.
  - exc=1 samples: only rpt_skip increments, and their diff is ignored.
- Stage 2 update rules:
  - rpt_sum saturates at all-ones.
  - rpt_max = max(rpt_max, diff).
  - rpt_nz increments when diff is nonzero.
  - rpt_samples increments for each non-skipped sample.
  - Counters saturate at all-ones and never wrap.
- DRAIN:
  - in_ready is 0.
  - Wait until both pipeline stages are empty, at most 2 cycles, then go to REPORT.
- REPORT:
  - rpt_valid is 1, and the rpt_* outputs are stable while it is high.
  - On rpt_ready, go to IDLE and drop rpt_valid the next cycle. The statistics are kept until the next start.
- Other rules:
  - start outside IDLE and flush outside RUN are ignored.
  - A flush with zero accepted samples still produces a report with all fields 0.
  - rst_n asserted mid-window discards everything immediately.

Optional Feature:
- MULT_ERR_HIST_EN defined:
  - Adds output rpt_hist, width 8*CNT_W: eight saturating bins updated in stage 2 for non-skipped samples.
  - Bin 0 counts diff=0.
  - Bin k, for k=1..6, counts diff in [2^(k-1), 2^k).
  - Bin 7 counts diff ≥ 64.
  - The bins are cleared on start and held in REPORT.
- Not defined: no histogram logic and no rpt_hist port.

Test Plan:
- Reset, then start, then 4 samples with WINDOW=4:
  - exact/approx pairs 0x3F800000/0x3F800000, 0x40000000/0x3FFFFFFF, 0x40400000/0x40400003 and 0x3F800001/0x3F800000.
  - Required report: rpt_sum=5, rpt_max=3, rpt_nz=3, rpt_samples=4, rpt_skip=0, sign_err=0.
- WINDOW=4, samples 2 and 3 with exc=1:
  - Required report: rpt_skip=2, rpt_samples=2, and only the diffs of samples 1 and 4 summed.
- Back-pressure: in_valid held high for 10 cycles with WINDOW=4.
  - Exactly 4 samples accepted; in_ready falls after the 4th.
  - rpt_valid stays high for 5 cycles while rpt_ready=0, with fields stable; it drops one cycle after rpt_ready=1.
- Flush after 2 samples:
  - Report rpt_samples=2.
  - A flush in the same cycle as a valid sample does not count that sample.
  - A start pulse during REPORT is ignored.
- Pair 0x3F800000/0xBF800000:
  - Required response: sign_err=1, diff=0, rpt_nz=0.
  - rst_n low in the middle of a window clears busy, in_ready and rpt_valid asynchronously.
- With MULT_ERR_HIST_EN, diffs 0, 1, 5, 100:
  - Required histogram: bins 0, 1, 3 and 7 each equal 1; all other bins 0.
